usb_rx_ctrl: RTL
================

// Module: usb_rx_ctrl
// PURPOSE
//  Receive-side sequencer for the USB 1.1 RX datapath. Drives the bit/byte/EOP/address
//  timer (rx_transfer_active, addr_en, eop_en) and consumes its flags to walk a packet:
//  SYNC -> PID -> token address or data payload -> EOP -> idle.
//  Captures PID and payload bytes, writes payload bytes to the RX FIFO and reports errors.
// PARAMETERS
//  SYNC_BYTE   8'h80  required value of first received byte (shift-register order)
//  MAX_BYTES   64     max payload bytes incl. CRC16; one more byte -> error
//  CNT_W       7      width of byte_count; must hold MAX_BYTES
// PORTS
//  clk            in   1      system clock; one clock
//  rst            in   1      reset; asynchronous, active-high
//  d_edge         in   1      D+ transition seen while idle (packet start)
//  eop            in   1      SE0 present on current sample
//  line_j         in   1      bus at J (idle) on current sample
//  shift_en       in   1      timer: bit sample strobe (unused in FSM, qualifies nothing)
//  byte_received  in   1      timer: 8th bit of current byte sampled, 1-cycle pulse
//  address_comp   in   1      timer: addr+endp+CRC5 field complete, 1-cycle pulse
//  eop_1_comp     in   1      timer: first EOP bit time elapsed
//  eop_comp       in   1      timer: full EOP (SE0,SE0,J) elapsed
//  rcv_data       in   8      shift-register byte, valid when byte_received=1
//  fifo_full      in   1      RX FIFO cannot accept a write
//  rx_transfer_active out 1   high in SYNC..EOP2; low clears all timer counters
//  addr_en        out  1      high only in ADDR
//  eop_en         out  1      high in EOP1 and EOP2
//  rx_pid         out  4      last valid PID (low nibble)
//  rx_data        out  8      last payload byte written
//  w_enable       out  1      1-cycle FIFO write strobe
//  byte_count     out  CNT_W  payload bytes accepted in current packet
//  rx_packet_done out  1      1-cycle pulse on error-free packet end
//  r_error        out  1      sticky error flag
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (rx_pid 4'h0, rx_data 8'h00, byte_count 0).
//  rst asserted mid-packet -> immediate IDLE; no w_enable/done pulse emitted.
//  All outputs registered; FSM and strobes update on rising clk.
//  IDLE : d_edge -> SYNC, clears r_error and byte_count.
//  SYNC : byte_received & rcv_data==SYNC_BYTE -> PID; byte_received & mismatch -> ERROR;
//         eop -> ERROR.
//  PID  : on byte_received: rcv_data[7:4] != ~rcv_data[3:0] -> ERROR; else latch
//         rx_pid=rcv_data[3:0] and branch on rcv_data[1:0]: 01 token -> ADDR,
//         11 data -> DATA, 10 handshake -> EOP_WAIT, 00 special -> ERROR. eop -> ERROR.
//  ADDR : address_comp -> EOP_WAIT; eop before address_comp -> ERROR.
//  DATA : byte_received & !fifo_full & byte_count<MAX_BYTES -> next cycle w_enable=1,
//         rx_data=rcv_data, byte_count+1. byte_received & (fifo_full | count==MAX_BYTES)
//         -> ERROR, no write. eop & byte_count>=2 -> EOP1; eop & byte_count<2 -> ERROR.
//         byte_received & eop same cycle: byte accepted/written first, count includes
//         it for the >=2 check, then EOP1.
//  EOP_WAIT: eop -> EOP1; byte_received (extra byte after handshake/addr) -> ERROR.
//  EOP1 : eop_en=1; eop drops before eop_1_comp -> ERROR; eop_1_comp -> EOP2.
//  EOP2 : eop_en=1; eop_comp & line_j -> DONE; eop_comp & !line_j -> ERROR.
//  DONE : rx_packet_done=1 one cycle; -> IDLE.
//  ERROR: r_error=1 (stays 1 until next d_edge in IDLE); rx_transfer_active=0;
//         -> IDLE when line_j & !eop.
//  byte_count saturates at MAX_BYTES; never wraps. d_edge ignored outside IDLE.
// TESTING
//  1 Token: d_edge, 8'h80, PID 8'hE1 (OUT), address_comp, 2-bit EOP, J -> addr_en high
//    in ADDR only, rx_pid=4'h1, rx_packet_done one cycle, w_enable never high.
//  2 Data: 8'h80, PID 8'hC3 (DATA0), bytes 8'h11,8'h22,CRC 8'hAA,8'h55, EOP -> four
//    w_enable pulses with rx_data 11,22,AA,55; byte_count=4; done pulse; r_error=0.
//  3 Bad PID 8'hE2 after sync -> ERROR next cycle, r_error=1, rx_transfer_active=0;
//    r_error stays 1 through idle until next d_edge.
//  4 Bad sync 8'h81 -> ERROR; next well-formed ACK (8'hD2) packet completes, r_error cleared.
//  5 DATA1 with fifo_full raised on 3rd byte -> no 3rd w_enable, ERROR, byte_count=2.
//  6 eop and byte_received same cycle with byte_count=1 -> byte written, count=2, EOP1;
//    separate run: rst asserted in DATA -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/usb_rx_ctrl.sv
// USB 1.1 receive sequencer: walks SYNC, PID, token address or data payload and EOP using the
// bit timer's strobes, writes payload bytes to the RX FIFO and flags malformed packets.
module usb_rx_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             line_j,
    input  logic             shift_en,
    input  logic             byte_received,
    input  logic             address_comp,
    input  logic             eop_1_comp,
    input  logic             eop_comp,
    input  logic [7:0]       rcv_data,
    input  logic             fifo_full,
    output logic             rx_transfer_active,
    output logic             addr_en,
    output logic             eop_en,
    output logic [3:0]       rx_pid,
    output logic [7:0]       rx_data,
    output logic             w_enable,
    output logic [CNT_W-1:0] byte_count,
    output logic             rx_packet_done,
    output logic             r_error
);

    typedef enum logic [3:0] {
        StIdle, StSync, StPid, StAddr, StData, StEopWait, StEop1, StEop2, StDone, StError
    } state_e;

    localparam logic [CNT_W-1:0] MaxCount = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] MinCount = CNT_W'(2);

    state_e           state_q, state_d;
    logic [3:0]       rx_pid_q, rx_pid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d, count_inc;
    logic             w_enable_q, w_enable_d;
    logic             r_error_q, r_error_d;
    logic             active_q, active_d;
    logic             addr_en_q, addr_en_d;
    logic             eop_en_q, eop_en_d;
    logic             done_q, done_d;
    logic             pid_ok;

    // The bit-sample strobe is only consumed by the timer.
    logic unused_shift_en;
    assign unused_shift_en = shift_en;

    assign pid_ok = (rcv_data[7:4] == ~rcv_data[3:0]);

    always_comb begin
        state_d      = state_q;
        rx_pid_d     = rx_pid_q;
        rx_data_d    = rx_data_q;
        byte_count_d = byte_count_q;
        w_enable_d   = 1'b0;
        r_error_d    = r_error_q;
        count_inc    = byte_count_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (d_edge) begin
                    state_d      = StSync;
                    r_error_d    = 1'b0;
                    byte_count_d = '0;
                end
            end
            StSync: begin
                if (eop) begin
                    state_d = StError;
                end else if (byte_received) begin
                    state_d = (rcv_data == SYNC_BYTE) ? StPid : StError;
                end
            end
            StPid: begin
                if (eop) begin
                    state_d = StError;
                end else if (byte_received) begin
                    if (!pid_ok) begin
                        state_d = StError;
                    end else begin
                        rx_pid_d = rcv_data[3:0];
                        case (rcv_data[1:0])
                            2'b01:   state_d = StAddr;
                            2'b11:   state_d = StData;
                            2'b10:   state_d = StEopWait;
                            default: state_d = StError;
                        endcase
                    end
                end
            end
            StAddr: begin
                if (address_comp) begin
                    state_d = StEopWait;
                end else if (eop) begin
                    state_d = StError;
                end
            end
            StData: begin
                // A byte landing with the first SE0 sample is counted before the length check.
                if (byte_received) begin
                    if (fifo_full || byte_count_q >= MaxCount) begin
                        state_d = StError;
                    end else begin
                        w_enable_d   = 1'b1;
                        rx_data_d    = rcv_data;
                        byte_count_d = count_inc;
                        if (eop) begin
                            state_d = (count_inc >= MinCount) ? StEop1 : StError;
                        end
                    end
                end else if (eop) begin
                    state_d = (byte_count_q >= MinCount) ? StEop1 : StError;
                end
            end
            StEopWait: begin
                if (byte_received) begin
                    state_d = StError;
                end else if (eop) begin
                    state_d = StEop1;
                end
            end
            StEop1: begin
                if (eop_1_comp) begin
                    state_d = StEop2;
                end else if (!eop) begin
                    state_d = StError;
                end
            end
            StEop2: begin
                if (eop_comp) begin
                    state_d = line_j ? StDone : StError;
                end
            end
            StDone: state_d = StIdle;
            StError: begin
                if (line_j && !eop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StError) begin
            r_error_d = 1'b1;
        end

        // Outputs are decoded from the next state so they line up with the state register.
        active_d  = (state_d inside {StSync, StPid, StAddr, StData, StEopWait, StEop1, StEop2});
        addr_en_d = (state_d == StAddr);
        eop_en_d  = (state_d == StEop1) || (state_d == StEop2);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rx_pid_q     <= 4'h0;
            rx_data_q    <= 8'h00;
            byte_count_q <= '0;
            w_enable_q   <= 1'b0;
            r_error_q    <= 1'b0;
            active_q     <= 1'b0;
            addr_en_q    <= 1'b0;
            eop_en_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_pid_q     <= rx_pid_d;
            rx_data_q    <= rx_data_d;
            byte_count_q <= byte_count_d;
            w_enable_q   <= w_enable_d;
            r_error_q    <= r_error_d;
            active_q     <= active_d;
            addr_en_q    <= addr_en_d;
            eop_en_q     <= eop_en_d;
            done_q       <= done_d;
        end
    end

    assign rx_transfer_active = active_q;
    assign addr_en            = addr_en_q;
    assign eop_en             = eop_en_q;
    assign rx_pid             = rx_pid_q;
    assign rx_data            = rx_data_q;
    assign w_enable           = w_enable_q;
    assign byte_count         = byte_count_q;
    assign rx_packet_done     = done_q;
    assign r_error            = r_error_q;

endmodule
